// File: rtl/icache_refill_if.sv
// Miss-request and L2 line-read handshake bundle between the fetch pipeline,
// the refill engine (master) and the L2 / pipeline side (slave).
interface icache_refill_if #(
    parameter int PADDR_W = 56,
    parameter int BEAT_W  = 128
);
    logic               i_miss_valid;
    logic               o_miss_ready;
    logic [PADDR_W-1:0] i_miss_paddr;
    logic               o_l2_req_valid;
    logic               i_l2_req_ready;
    logic [PADDR_W-1:0] o_l2_req_paddr;
    logic               i_l2_resp_valid;
    logic               o_l2_resp_ready;
    logic [BEAT_W-1:0]  i_l2_resp_data;

    modport master (
        input  i_miss_valid, i_miss_paddr, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_data,
        output o_miss_ready, o_l2_req_valid, o_l2_req_paddr, o_l2_resp_ready
    );

    modport slave (
        output i_miss_valid, i_miss_paddr, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_data,
        input  o_miss_ready, o_l2_req_valid, o_l2_req_paddr, o_l2_resp_ready
    );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: invalidates all tags after reset, then turns
// each miss into one L2 line read, assembles the beats and writes a round-robin way.
module icache_refill #(
    parameter int PADDR_W = 56,
    parameter int WAYS    = 4,
    parameter int INDEX_W = 6,
    parameter int LINE_W  = 512,
    parameter int BEAT_W  = 128
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    icache_refill_if.master                         bus,
    output logic [WAYS-1:0]                         o_tag_we,
    output logic [INDEX_W-1:0]                      o_tag_index,
    output logic [PADDR_W-INDEX_W-$clog2(LINE_W/8)-1:0] o_tag_wdata,
    output logic                                    o_tag_wvalid,
    output logic [WAYS-1:0]                         o_data_we,
    output logic [LINE_W-1:0]                       o_data_wdata,
    output logic                                    o_refill_done,
    output logic                                    o_busy
);
    localparam int OFS_W  = $clog2(LINE_W/8);
    localparam int TAG_W  = PADDR_W - INDEX_W - OFS_W;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VIC_W  = $clog2(WAYS);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_REQ, S_FILL, S_WRITE} state_t;

    state_t              state_q, state_d;
    logic [INDEX_W-1:0]  init_cnt_q, init_cnt_d;
    logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [VIC_W-1:0]    victim_q, victim_d;
    logic [PADDR_W-1:0]  paddr_q, paddr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [WAYS-1:0]     victim_oh;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_victim_oh
            assign victim_oh[gi] = (victim_q == VIC_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            beat_cnt_q <= '0;
            victim_q   <= '0;
            paddr_q    <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            victim_q   <= victim_d;
            paddr_q    <= paddr_d;
            line_q     <= line_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        beat_cnt_d = beat_cnt_q;
        victim_d   = victim_q;
        paddr_d    = paddr_q;
        line_d     = line_q;
        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.i_miss_valid) begin
                    paddr_d = {bus.i_miss_paddr[PADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.i_l2_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                // Beats arrive in ascending address order, so the counter is the slot.
                if (bus.i_l2_resp_valid) begin
                    line_d[beat_cnt_q*BEAT_W +: BEAT_W] = bus.i_l2_resp_data;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BCNT_W'(BEATS-1)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                victim_d = victim_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        bus.o_miss_ready    = 1'b0;
        bus.o_l2_req_valid  = 1'b0;
        bus.o_l2_req_paddr  = paddr_q;
        bus.o_l2_resp_ready = 1'b0;
        o_tag_we            = '0;
        o_tag_index         = '0;
        o_tag_wdata         = '0;
        o_tag_wvalid        = 1'b0;
        o_data_we           = '0;
        o_data_wdata        = line_q;
        o_refill_done       = 1'b0;
        o_busy              = (state_q != S_IDLE);
        case (state_q)
            S_INIT: begin
                o_tag_we    = '1;
                o_tag_index = init_cnt_q;
            end
            S_IDLE:  bus.o_miss_ready    = 1'b1;
            S_REQ:   bus.o_l2_req_valid  = 1'b1;
            S_FILL:  bus.o_l2_resp_ready = 1'b1;
            S_WRITE: begin
                o_tag_we      = victim_oh;
                o_data_we     = victim_oh;
                o_tag_index   = paddr_q[OFS_W +: INDEX_W];
                o_tag_wdata   = paddr_q[PADDR_W-1 -: TAG_W];
                o_tag_wvalid  = 1'b1;
                o_refill_done = 1'b1;
            end
            default: ;
        endcase
        // The reset cycle itself must look like an inert, busy engine.
        if (i_reset) begin
            bus.o_miss_ready    = 1'b0;
            bus.o_l2_req_valid  = 1'b0;
            bus.o_l2_resp_ready = 1'b0;
            o_tag_we            = '0;
            o_data_we           = '0;
            o_refill_done       = 1'b0;
            o_busy              = 1'b1;
        end
    end
endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 Parameter PADDR_W, default 56, physical address width.
REQ-002 Parameter WAYS, default 4, number of cache ways (power of 2, >=2).
REQ-003 Parameter INDEX_W, default 6, set index width.
REQ-004 Parameter LINE_W, default 512, cache line width in bits; line offset width OFS_W = log2(LINE_W/8) = 6.
REQ-005 Parameter BEAT_W, default 128, L2 response beat width; BEATS = LINE_W/BEAT_W = 4.
REQ-006 i_clk  in  1  single clock; all state changes on rising edge.
REQ-007 i_reset  in  1  reset, synchronous, active-high.
REQ-008 i_miss_valid  in  1  miss request from fetch pipeline.
REQ-009 o_miss_ready  out  1  miss request accepted when valid & ready.
REQ-010 i_miss_paddr  in  PADDR_W  missing physical address.
REQ-011 o_l2_req_valid / i_l2_req_ready  out/in  1  L2 line-read request handshake.
REQ-012 o_l2_req_paddr  out  PADDR_W  line-aligned request address (low OFS_W bits zero).
REQ-013 i_l2_resp_valid / o_l2_resp_ready  in/out  1  L2 beat handshake.
REQ-014 i_l2_resp_data  in  BEAT_W  response beat, beats returned in ascending address order.
REQ-015 o_tag_we  out  WAYS  one-hot (or all-ones during init) tag-array write enable.
REQ-016 o_tag_index  out  INDEX_W  tag/data array set index.
REQ-017 o_tag_wdata  out  PADDR_W-INDEX_W-OFS_W  tag written.
REQ-018 o_tag_wvalid  out  1  valid bit written with tag.
REQ-019 o_data_we  out  WAYS  one-hot data-array write enable.
REQ-020 o_data_wdata  out  LINE_W  assembled line.
REQ-021 o_refill_done  out  1  one-cycle pulse when line is written.
REQ-022 o_busy  out  1  high in every state except IDLE.

Function
REQ-023 FSM states: INIT, IDLE, REQ, FILL, WRITE; only transitions listed below.
REQ-024 INIT: init counter 0..2^INDEX_W-1; each cycle o_tag_we=all-ones, o_tag_index=counter, o_tag_wvalid=0, o_tag_wdata=0; after index 2^INDEX_W-1 written, next state IDLE (INIT lasts exactly 2^INDEX_W cycles).
REQ-025 IDLE: o_miss_ready=1; on i_miss_valid capture paddr with low OFS_W bits cleared, go REQ next cycle.
REQ-026 o_miss_ready=0 in all states but IDLE; misses presented while busy are not captured.
REQ-027 REQ: o_l2_req_valid=1, o_l2_req_paddr=captured address, held stable until i_l2_req_ready; on handshake go FILL, beat counter=0.
REQ-028 FILL: o_l2_resp_ready=1; each accepted beat k stored in line buffer bits [k*BEAT_W +: BEAT_W]; counter increments; accepting beat BEATS-1 moves to WRITE.
REQ-029 o_l2_resp_ready=0 outside FILL; beats arriving outside FILL are not accepted and not stored.
REQ-030 FILL with no i_l2_resp_valid holds state and counter indefinitely (no timeout).
REQ-031 WRITE (exactly one cycle): o_tag_we=o_data_we=onehot(victim), o_tag_index=paddr[OFS_W+INDEX_W-1:OFS_W], o_tag_wdata=paddr[PADDR_W-1:OFS_W+INDEX_W], o_tag_wvalid=1, o_data_wdata=line buffer, o_refill_done=1; next state IDLE.
REQ-032 Victim pointer is round-robin, log2(WAYS) bits, increments after each WRITE, wraps WAYS-1 -> 0.
REQ-033 All write enables, o_refill_done, o_l2_req_valid are 0 in any state where not explicitly asserted above.
REQ-034 Miss-to-done latency with zero-wait L2: 1 (IDLE accept) + 1 (REQ) + BEATS (FILL) + 1 (WRITE) = 7 cycles for defaults.

Reset
REQ-035 i_reset high at any edge, including mid-REQ/FILL/WRITE: next state INIT, init counter 0, beat counter 0, victim pointer 0, captured address and line buffer cleared; any in-flight L2 transaction is abandoned.
REQ-036 During reset cycle and INIT, o_miss_ready=0, o_l2_req_valid=0, o_l2_resp_ready=0, o_data_we=0, o_refill_done=0, o_busy=1.

Verification
REQ-037 Reset release -> exactly 64 cycles of o_tag_we=4'b1111, wvalid=0, index 0..63 ascending, then o_miss_ready=1.
REQ-038 Miss paddr 0x0000_1234_5678 with zero-wait L2, beats 0xA..,0xB..,0xC..,0xD.. -> req paddr 0x...5640, WRITE index 0x19, tag 0x1234_5, way0, line = {D,C,B,A}, done 7 cycles after accept.
REQ-039 Five back-to-back misses -> victim ways 0,1,2,3,0.
REQ-040 i_l2_req_ready low 3 cycles, resp_valid gaps between beats -> req held stable, only valid beats counted, single WRITE.
REQ-041 Second miss asserted during FILL -> not accepted until IDLE; accepted next IDLE cycle.
REQ-042 i_reset pulsed after beat 2 in FILL -> no WRITE, INIT re-run, victim restarts at way0.
